// File: rtl/sonic_echo_emulator.sv
// HC-SR04 style echo responder: validates trigger width, waits a fixed delay, then drives a programmable echo pulse.
// Optional echo-length jitter is enabled by defining SONIC_EMU_JITTER_EN.
module sonic_echo_emulator #(
    parameter int unsigned TRIG_MIN   = 500,
    parameter int unsigned RESP_DELAY = 2000,
    parameter int unsigned CNT_W      = 22
) (
    input  logic        av_mm_clk,
    input  logic        av_mm_rst,
    input  logic        av_mm_cs,
    input  logic        av_mm_read,
    input  logic        av_mm_write,
    input  logic [1:0]  av_mm_address,
    input  logic [31:0] av_mm_writedata,
    output logic [31:0] av_mm_readdata,
    input  logic        sonic_trigger,
    output logic        sonic_echo
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIG  = 2'd1,
        DELAY = 2'd2,
        ECHO  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] TRIG_MIN_C   = CNT_W'(TRIG_MIN);
    localparam logic [CNT_W-1:0] RESP_DELAY_C = CNT_W'(RESP_DELAY);
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

    state_e             state_q, state_d;
    logic [2:0]         trig_sync_q, trig_sync_d;
    logic [CNT_W-1:0]   echo_len_q, echo_len_d;
    logic               enable_q, enable_d;
    logic               clr_q, clr_d;
    logic [7:0]         reject_q, reject_d;
    logic [7:0]         echo_cnt_q, echo_cnt_d;
    logic [CNT_W-1:0]   last_width_q, last_width_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [CNT_W-1:0]   dly_q, dly_d;
    logic [CNT_W-1:0]   wrk_q, wrk_d;
    logic               echo_q, echo_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               rise, fall, wr, rd, busy;
    logic [2:0]         jitter_add;
    logic [2:0]         status_jit;
    logic               unused_wdata;

`ifdef SONIC_EMU_JITTER_EN
    logic [15:0]        lfsr_q, lfsr_d;
    logic [2:0]         jit_q, jit_d;
    logic               lfsr_fb;

    assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign jitter_add = lfsr_q[2:0];
    assign status_jit = jit_q;
`else
    assign jitter_add = '0;
    assign status_jit = '0;
`endif

    assign unused_wdata = ^av_mm_writedata;

    // Edge detect compares the 2nd sync flop with a 3rd delay flop
    assign rise = trig_sync_q[1] & ~trig_sync_q[2];
    assign fall = ~trig_sync_q[1] & trig_sync_q[2];
    assign wr   = av_mm_cs & av_mm_write;
    assign rd   = av_mm_cs & av_mm_read;
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        trig_sync_d  = {trig_sync_q[1:0], sonic_trigger};
        echo_len_d   = echo_len_q;
        enable_d     = enable_q;
        clr_d        = 1'b0;
        reject_d     = reject_q;
        echo_cnt_d   = echo_cnt_q;
        last_width_d = last_width_q;
        width_d      = width_q;
        dly_d        = dly_q;
        wrk_d        = wrk_q;
        echo_d       = echo_q;
        rdata_d      = rdata_q;
`ifdef SONIC_EMU_JITTER_EN
        lfsr_d       = lfsr_q;
        jit_d        = jit_q;
`endif

        if (wr) begin
            case (av_mm_address)
                2'd0: echo_len_d = av_mm_writedata[CNT_W-1:0];
                2'd1: begin
                    enable_d = av_mm_writedata[0];
                    clr_d    = av_mm_writedata[1];
                end
                default: ;
            endcase
        end

        if (rd) begin
            case (av_mm_address)
                2'd0:    rdata_d = 32'(echo_len_q);
                2'd1:    rdata_d = {31'd0, enable_q};
                2'd2:    rdata_d = {5'd0, status_jit, reject_q, echo_cnt_q, 7'd0, busy};
                default: rdata_d = 32'(last_width_q);
            endcase
        end

        case (state_q)
            IDLE: begin
                echo_d = 1'b0;
                if (rise && enable_q) begin
                    state_d = TRIG;
                    width_d = ONE_C;
                end
            end
            TRIG: begin
                if (!enable_q) begin
                    state_d = IDLE;
                end else if (fall) begin
                    last_width_d = width_q;
                    if ((width_q >= TRIG_MIN_C) && (echo_len_q != '0)) begin
                        state_d = DELAY;
                        dly_d   = RESP_DELAY_C;
                        wrk_d   = echo_len_q + CNT_W'(jitter_add);
`ifdef SONIC_EMU_JITTER_EN
                        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                        jit_d   = lfsr_q[2:0];
`endif
                    end else begin
                        state_d = IDLE;
                        if (reject_q != 8'hFF) reject_d = reject_q + 8'd1;
                    end
                end else if (width_q != '1) begin
                    width_d = width_q + ONE_C;
                end
            end
            DELAY: begin
                if (!enable_q) begin
                    state_d = IDLE;
                end else if (dly_q == ONE_C) begin
                    state_d = ECHO;
                    echo_d  = 1'b1;
                end else begin
                    dly_d = dly_q - ONE_C;
                end
            end
            ECHO: begin
                if (!enable_q) begin
                    state_d = IDLE;
                    echo_d  = 1'b0;
                end else if (wrk_q == ONE_C) begin
                    state_d = IDLE;
                    echo_d  = 1'b0;
                    if (echo_cnt_q != 8'hFF) echo_cnt_d = echo_cnt_q + 8'd1;
                end else begin
                    wrk_d = wrk_q - ONE_C;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered clear pulse overrides any increment landing on the same edge
        if (clr_q) begin
            reject_d   = '0;
            echo_cnt_d = '0;
        end
    end

    always_ff @(posedge av_mm_clk or negedge av_mm_rst) begin
        if (!av_mm_rst) begin
            state_q      <= IDLE;
            trig_sync_q  <= '0;
            echo_len_q   <= '0;
            enable_q     <= 1'b0;
            clr_q        <= 1'b0;
            reject_q     <= '0;
            echo_cnt_q   <= '0;
            last_width_q <= '0;
            width_q      <= '0;
            dly_q        <= '0;
            wrk_q        <= '0;
            echo_q       <= 1'b0;
            rdata_q      <= '0;
`ifdef SONIC_EMU_JITTER_EN
            lfsr_q       <= 16'hACE1;
            jit_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            trig_sync_q  <= trig_sync_d;
            echo_len_q   <= echo_len_d;
            enable_q     <= enable_d;
            clr_q        <= clr_d;
            reject_q     <= reject_d;
            echo_cnt_q   <= echo_cnt_d;
            last_width_q <= last_width_d;
            width_q      <= width_d;
            dly_q        <= dly_d;
            wrk_q        <= wrk_d;
            echo_q       <= echo_d;
            rdata_q      <= rdata_d;
`ifdef SONIC_EMU_JITTER_EN
            lfsr_q       <= lfsr_d;
            jit_q        <= jit_d;
`endif
        end
    end

    assign sonic_echo     = echo_q;
    assign av_mm_readdata = rdata_q;

endmodule

// File: tb/tb_sonic_echo_emulator.sv
// Directed bench for sonic_echo_emulator: bus access, echo timing, rejects, aborts and reset.
module tb_sonic_echo_emulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs, rd_s, wr_s;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        trig;
    logic        echo;

    int tests = 0;
    int fails = 0;

    sonic_echo_emulator #(.TRIG_MIN(500), .RESP_DELAY(2000), .CNT_W(22)) dut (
        .av_mm_clk       (clk),
        .av_mm_rst       (rst_n),
        .av_mm_cs        (cs),
        .av_mm_read      (rd_s),
        .av_mm_write     (wr_s),
        .av_mm_address   (addr),
        .av_mm_writedata (wdata),
        .av_mm_readdata  (rdata),
        .sonic_trigger   (trig),
        .sonic_echo      (echo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Echo pulse monitor: count, rise time and high length in clocks
    bit echo_prev = 1'b0;
    int pulses = 0, run = 0, last_len = 0, rise_cyc = 0;
    always @(negedge clk) begin
        echo_prev <= echo;
        if (echo && !echo_prev) begin
            pulses   <= pulses + 1;
            rise_cyc <= cyc;
            run      <= 1;
        end else if (echo) begin
            run <= run + 1;
        end
        if (!echo && echo_prev) last_len <= run;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wr_s = 1'b1; addr = a; wdata = d;
        tick(1);
        cs = 1'b0; wr_s = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        cs = 1'b1; rd_s = 1'b1; addr = a;
        tick(1);
        cs = 1'b0; rd_s = 1'b0;
        d = rdata;
    endtask

    task automatic pulse_trig(input int h);
        trig = 1'b1;
        tick(h);
        trig = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int tf;
        rst_n = 1'b0; cs = 1'b0; rd_s = 1'b0; wr_s = 1'b0;
        addr = '0; wdata = '0; trig = 1'b0;
        tick(3);
        check("rst_echo", {31'd0, echo}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick(2);
        bus_read(2'd0, r); check("rst_echo_len", r, 32'd0);
        bus_read(2'd1, r); check("rst_ctrl", r, 32'd0);
        bus_read(2'd2, r); check("rst_status", r, 32'd0);
        bus_read(2'd3, r); check("rst_last_width", r, 32'd0);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, r); check("echo_len_mask", r, 32'h003F_FFFF);

        // Nominal 600-clk trigger, 5800-clk echo
        bus_write(2'd0, 32'd5800);
        bus_write(2'd1, 32'd1);
        bus_read(2'd0, r); check("echo_len_rb", r, 32'd5800);
        bus_read(2'd1, r); check("ctrl_rb", r, 32'd1);
        pulse_trig(600); tf = cyc;
        tick(10);
        bus_read(2'd2, r); check("busy_in_delay", r, 32'h0000_0001);
        tick(7810);
        check("t1_pulses", pulses, 32'd1);
        check("t1_rise_delay", rise_cyc - tf, 32'd2003);
        check("t1_len", last_len, 32'd5800);
        bus_read(2'd2, r); check("t1_status", r, 32'h0000_0100);
        bus_read(2'd3, r); check("t1_last_width", r, 32'd600);
        tick(1);
        check("rdata_hold", rdata, 32'd600);

        // Width boundary: 499 rejected, 500 accepted
        pulse_trig(499);
        tick(10);
        bus_read(2'd2, r); check("t2_reject_status", r, 32'h0001_0100);
        bus_read(2'd3, r); check("t2_width_499", r, 32'd499);
        check("t2_no_echo", pulses, 32'd1);
        bus_write(2'd0, 32'd200);
        pulse_trig(500); tf = cyc;
        tick(2213);
        check("t2_pulses", pulses, 32'd2);
        check("t2_rise_delay", rise_cyc - tf, 32'd2003);
        check("t2_len", last_len, 32'd200);
        bus_read(2'd2, r); check("t2_status", r, 32'h0001_0200);
        bus_read(2'd3, r); check("t2_width_500", r, 32'd500);

        // Disabled: trigger ignored
        bus_write(2'd1, 32'd0);
        pulse_trig(600);
        tick(2300);
        check("t3_dis_pulses", pulses, 32'd2);
        bus_read(2'd2, r); check("t3_dis_status", r, 32'h0001_0200);
        bus_read(2'd3, r); check("t3_dis_width", r, 32'd500);

        // Enable dropped 100 clks into echo
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'd1000);
        pulse_trig(600); tf = cyc;
        tick(2103);
        bus_write(2'd1, 32'd0);
        check("t3_echo_still_high", {31'd0, echo}, 32'd1);
        tick(1);
        check("t3_echo_dropped", {31'd0, echo}, 32'd0);
        bus_read(2'd2, r); check("t3_abort_status", r, 32'h0001_0200);
        check("t3_abort_pulses", pulses, 32'd3);
        check("t3_abort_len", last_len, 32'd102);

        // Triggers during DELAY and ECHO ignored
        bus_write(2'd1, 32'd1);
        bus_write(2'd0, 32'd300);
        pulse_trig(700); tf = cyc;
        tick(500);
        pulse_trig(600);
        tick(950);
        pulse_trig(100);
        tick(200);
        check("t4_pulses", pulses, 32'd4);
        check("t4_rise_delay", rise_cyc - tf, 32'd2003);
        check("t4_len", last_len, 32'd300);
        bus_read(2'd2, r); check("t4_status", r, 32'h0001_0300);
        bus_read(2'd3, r); check("t4_width", r, 32'd700);

        // Trigger held high across return to IDLE starts nothing
        bus_write(2'd0, 32'd20);
        pulse_trig(600);
        tick(2010);
        trig = 1'b1;
        tick(100);
        bus_read(2'd2, r); check("t4b_idle_trig_high", r, 32'h0001_0400);
        trig = 1'b0;
        tick(10);
        bus_read(2'd2, r); check("t4b_no_new_cycle", r, 32'h0001_0400);
        check("t4b_pulses", pulses, 32'd5);
        check("t4b_len", last_len, 32'd20);

        // echo_len rewritten mid-echo applies to the next response
        bus_write(2'd0, 32'd1000);
        pulse_trig(600);
        tick(2503);
        bus_write(2'd0, 32'd100);
        bus_read(2'd0, r); check("t5_echo_len_rb", r, 32'd100);
        tick(1);
        check("t5_rdata_hold", rdata, 32'd100);
        tick(600);
        check("t5_cur_len", last_len, 32'd1000);
        pulse_trig(600); tf = cyc;
        tick(2110);
        check("t5_pulses", pulses, 32'd7);
        check("t5_next_len", last_len, 32'd100);
        check("t5_rise_delay", rise_cyc - tf, 32'd2003);

        // echo_len=0 rejects; clear coincident with an increment wins
        bus_write(2'd0, 32'd0);
        pulse_trig(600);
        tick(20);
        check("t6_no_echo", pulses, 32'd7);
        bus_read(2'd2, r); check("t6_reject_zero_len", r, 32'h0002_0600);
        bus_read(2'd3, r); check("t6_width", r, 32'd600);
        pulse_trig(499);
        tick(1);
        bus_write(2'd1, 32'd3);
        tick(5);
        bus_read(2'd2, r); check("t6_clear_wins", r, 32'h0000_0000);
        bus_read(2'd3, r); check("t6_width_499", r, 32'd499);
        bus_read(2'd1, r); check("t6_ctrl_after_clear", r, 32'd1);

        // Asynchronous reset mid-echo
        bus_write(2'd0, 32'd50);
        pulse_trig(600);
        tick(2010);
        check("t7_echo_high", {31'd0, echo}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_async_echo", {31'd0, echo}, 32'd0);
        check("t7_async_rdata", rdata, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        bus_read(2'd0, r); check("t7_echo_len", r, 32'd0);
        bus_read(2'd1, r); check("t7_ctrl", r, 32'd0);
        bus_read(2'd2, r); check("t7_status", r, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
